merge2_ctrl: RTL and testbench
==============================

Name: merge2_ctrl

Overview:
- Two-way merge controller for the parallel merge sort.
- Two sorted input FIFOs (A, B) each hold one run of run_len elements. The block compares the FIFO heads through the combinational peek port, pops the winner, and writes it to an output FIFO. The result is one sorted run of 2*run_len elements.
- Cascaded instances build the merge tree.

Parameters:
- DATA_WIDTH, 32, element width; unsigned compare.
- LOG2_DEPTH, 8, log2 of input FIFO depth; run_len is LOG2_DEPTH+1 bits wide (max 2**LOG2_DEPTH).
- DESCENDING, 0, 0 = ascending merge, 1 = descending merge.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; captures run_len, starts a merge (ignored unless IDLE)
- run_len  in  LOG2_DEPTH+1  elements per input run
- a_head  in  DATA_WIDTH  FIFO A peek (mem[rd_ptr]), valid when !a_empty
- a_empty  in  1  FIFO A empty
- a_rd_en  out  1  pop FIFO A this cycle
- b_head  in  DATA_WIDTH  FIFO B peek
- b_empty  in  1  FIFO B empty
- b_rd_en  out  1  pop FIFO B this cycle
- out_din  out  DATA_WIDTH  registered write data to output FIFO
- out_wr_en  out  1  registered write enable to output FIFO
- out_afull  in  1  output FIFO has at most 1 free slot
- busy  out  1  high from the cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse when the merged run is fully written

Behaviour:
- Reset values: all outputs 0, state IDLE, rem_a = rem_b = 0.
- FSM states: IDLE, MERGE, DRAIN_A, DRAIN_B, FLUSH, DONE.
- IDLE:
  - On start, load rem_a = rem_b = run_len.
  - If run_len = 0, go to DONE; else go to MERGE.
- MERGE:
  - Pop only when !a_empty && !b_empty && !out_afull.
  - Select A when a_head <= b_head (ascending) or a_head >= b_head (descending). Ties always go to A (stable).
  - A pop asserts exactly one of a_rd_en/b_rd_en combinationally and decrements that side's counter.
  - When a pop makes rem_a reach 0, go to DRAIN_B. When it makes rem_b reach 0, go to DRAIN_A.
  - If either input is empty or out_afull is high, stall with no rd_en and no state change.
- DRAIN_A: pop A whenever !a_empty && !out_afull; decrement rem_a. The pop making rem_a = 0 moves to FLUSH. DRAIN_B is symmetric.
- rd_en rules:
  - rd_en is never asserted while the corresponding empty is high.
  - rd_en is never asserted outside MERGE/DRAIN_x.
  - At most one rd_en is asserted per cycle.
- Output path:
  - out_wr_en(t+1) = a_rd_en(t) | b_rd_en(t).
  - out_din(t+1) = the popped head at t.
  - Latency is 1 cycle. out_afull guarantees the in-flight write fits.
  - out_din holds its last value when out_wr_en = 0.
- FLUSH: one cycle; the final out_wr_en occurs here. Next state is DONE.
- DONE: done = 1 for one cycle, then IDLE.
- busy: 1 in every state except IDLE.
- Throughput: one element per cycle when there is no starvation or backpressure. A run of 2N elements completes in 2N+2 cycles after start (start cycle excluded).
- Counters: LOG2_DEPTH+1 bits, no wrap. Never decremented below 0.
- start while busy: ignored; run_len is not resampled.
- Reset mid-operation: immediate return to IDLE with all outputs 0 next cycle. FIFO contents are the system's responsibility.
- Extra data in the input FIFOs beyond run_len: left unread (belongs to the next run).

Decomposition:
- Shared package merge_pkg holds:
  - state encoding localparams (IDLE=0 … DONE=5);
  - the COMPARE_LE/GE selection constant;
  - the default DATA_WIDTH and LOG2_DEPTH.
- One sub-module, merge2_cmp: combinational head comparator with a DESCENDING parameter, outputs sel_a. Reused by the future k-way tree.
- The FSM, counters and output register stay in merge2_ctrl.

Test Plan:
- Basic merge: A = {1,4,6,9}, B = {2,3,7,8}, run_len = 4, out_afull = 0 -> out_wr_en for 8 consecutive cycles with values 1,2,3,4,6,7,8,9; done pulses 10 cycles after start; busy is low afterward.
- Ties and stability: A = {5,5}, B = {5,5} tagged through the upper bits -> order A0,A1,B0,B1; b_rd_en stays low until rem_a = 0.
- Early exhaustion: A = {1,2,3}, B = {10,11,12}, run_len = 3 -> three A pops in MERGE, then DRAIN_B with three B pops; output is 1,2,3,10,11,12.
- Starvation and backpressure: b_empty held high for 3 cycles mid-merge, then out_afull high for 2 cycles -> no rd_en in any stalled cycle; output order is still correct; done is delayed by exactly 5 cycles.
- Boundary cases:
  - run_len = 0 -> done in the cycle after next with no rd_en;
  - run_len = 256, LOG2_DEPTH = 8 -> 512 ordered writes.
- Reset and start handling:
  - reset asserted after 3 pops -> next cycle all outputs 0 and busy = 0;
  - a new start with run_len = 2 merges correctly;
  - start pulsed while busy has no effect.

Source files
------------

// File: rtl/merge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : merge_pkg
//  Description : Shared types and constants for the merge-sort controllers.
//  Revision    : 1.0  initial release
// ============================================================================
package merge_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LOG2_DEPTH = 8;

    // Comparator selection modes: ascending picks the smaller head, descending the larger.
    localparam logic COMPARE_LE = 1'b0;
    localparam logic COMPARE_GE = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MERGE   = 3'd1,
        DRAIN_A = 3'd2,
        DRAIN_B = 3'd3,
        FLUSH   = 3'd4,
        DONE    = 3'd5
    } merge_state_e;

    function automatic logic cmp_mode(input int descending);
        return (descending != 0) ? COMPARE_GE : COMPARE_LE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/merge2_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : merge2_cmp
//  Description : Combinational two-head comparator; ties always select A.
//  Revision    : 1.0  initial release
// ============================================================================
module merge2_cmp
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DESCENDING = 0
) (
    input  logic [DATA_WIDTH-1:0] a_head,
    input  logic [DATA_WIDTH-1:0] b_head,
    output logic                  sel_a
);

    generate
        if (cmp_mode(DESCENDING) == COMPARE_GE) begin : g_desc
            assign sel_a = (a_head >= b_head);
        end else begin : g_asc
            assign sel_a = (a_head <= b_head);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/merge2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : merge2_ctrl
//  Description : Two-way run merger popping two sorted FIFOs into one output.
//  Revision    : 1.0  initial release
// ============================================================================
module merge2_ctrl
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH,
    parameter int DESCENDING = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LOG2_DEPTH:0]   run_len,
    input  logic [DATA_WIDTH-1:0] a_head,
    input  logic                  a_empty,
    output logic                  a_rd_en,
    input  logic [DATA_WIDTH-1:0] b_head,
    input  logic                  b_empty,
    output logic                  b_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_wr_en,
    input  logic                  out_afull,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = LOG2_DEPTH + 1;

    merge_state_e          state_q, state_d;
    logic [CNT_W-1:0]      rem_a_q, rem_a_d;
    logic [CNT_W-1:0]      rem_b_q, rem_b_d;
    logic [DATA_WIDTH-1:0] out_din_q, out_din_d;
    logic                  out_wr_en_q, out_wr_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  sel_a;
    logic                  pop_a;
    logic                  pop_b;
    logic                  a_ready;
    logic                  b_ready;

    merge2_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DESCENDING (DESCENDING)
    ) u_cmp (
        .a_head (a_head),
        .b_head (b_head),
        .sel_a  (sel_a)
    );

    // A side may pop only with data present, room downstream and elements left in its run.
    assign a_ready = !a_empty && !out_afull && (rem_a_q != '0);
    assign b_ready = !b_empty && !out_afull && (rem_b_q != '0);

    always_comb begin
        pop_a = 1'b0;
        pop_b = 1'b0;
        unique case (state_q)
            MERGE: begin
                if (a_ready && b_ready) begin
                    pop_a = sel_a;
                    pop_b = !sel_a;
                end
            end
            DRAIN_A: pop_a = a_ready;
            DRAIN_B: pop_b = b_ready;
            default: begin
                pop_a = 1'b0;
                pop_b = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_a_d = rem_a_q;
        rem_b_d = rem_b_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_a_d = run_len;
                    rem_b_d = run_len;
                    state_d = (run_len == '0) ? DONE : MERGE;
                end
            end
            MERGE: begin
                if (pop_a) begin
                    rem_a_d = rem_a_q - 1'b1;
                    if (rem_a_q == CNT_W'(1)) begin
                        state_d = DRAIN_B;
                    end
                end else if (pop_b) begin
                    rem_b_d = rem_b_q - 1'b1;
                    if (rem_b_q == CNT_W'(1)) begin
                        state_d = DRAIN_A;
                    end
                end
            end
            DRAIN_A: begin
                if (pop_a) begin
                    rem_a_d = rem_a_q - 1'b1;
                    if (rem_a_q == CNT_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            DRAIN_B: begin
                if (pop_b) begin
                    rem_b_d = rem_b_q - 1'b1;
                    if (rem_b_q == CNT_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status and write-path outputs are registered from next-state and pop decisions.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        out_wr_en_d = pop_a | pop_b;
        out_din_d   = out_din_q;
        if (pop_a) begin
            out_din_d = a_head;
        end else if (pop_b) begin
            out_din_d = b_head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_a_q     <= '0;
            rem_b_q     <= '0;
            out_din_q   <= '0;
            out_wr_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_a_q     <= rem_a_d;
            rem_b_q     <= rem_b_d;
            out_din_q   <= out_din_d;
            out_wr_en_q <= out_wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_rd_en   = pop_a;
    assign b_rd_en   = pop_b;
    assign out_din   = out_din_q;
    assign out_wr_en = out_wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_merge2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_merge2_ctrl
//  Description : Self-checking bench for merge2_ctrl against a queue-based merge model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_merge2_ctrl;

    localparam int DW = 32;
    localparam int LD = 8;
    localparam int CW = LD + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] run_len;
    logic [DW-1:0] a_head, b_head, out_din;
    logic          a_empty, b_empty, a_rd_en, b_rd_en;
    logic          out_wr_en, out_afull, busy, done;

    always #5 clk = ~clk;

    merge2_ctrl #(.DATA_WIDTH(DW), .LOG2_DEPTH(LD), .DESCENDING(0)) dut (
        .clk(clk), .reset(reset), .start(start), .run_len(run_len),
        .a_head(a_head), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_head(b_head), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .out_din(out_din), .out_wr_en(out_wr_en), .out_afull(out_afull),
        .busy(busy), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Input FIFO contents, the run under test and the expected merged stream.
    logic [DW-1:0] qa[$], qb[$], ra[$], rb[$];
    logic [DW-1:0] exp_val[$];
    bit            exp_src[$];
    logic [DW-1:0] last_din;
    bit            pend_a, pend_b;
    int cyc, n_writes, n_pops, last_wr_cyc, done_cyc, done_cnt;
    int bst_from = 0, bst_len = 0, af_from = 0, af_len = 0, rnd_pct = 0, spur_at = -1;

    // Stable two-way merge: smaller value first, equal values taken from A first.
    task automatic build_expect();
        int i, j;
        i = 0; j = 0;
        exp_val.delete(); exp_src.delete();
        while (i < ra.size() || j < rb.size()) begin
            if (j >= rb.size() || (i < ra.size() && ra[i] <= rb[j])) begin
                exp_val.push_back(ra[i]); exp_src.push_back(1'b1); i++;
            end else begin
                exp_val.push_back(rb[j]); exp_src.push_back(1'b0); j++;
            end
        end
    endtask

    task automatic tick();
        bit was_reset, sa, sb, af;
        logic [DW-1:0] e;
        was_reset = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (pend_a || pend_b) begin
            n_pops++;
            if (pend_a) void'(qa.pop_front());
            if (pend_b) void'(qb.pop_front());
            if (exp_src.size() == 0) check("pop_overrun", 1, 0);
            else check("pop_src", pend_a, exp_src.pop_front());
        end
        if (was_reset) begin
            check("rst_wr_en", out_wr_en, 0);
            check("rst_din", out_din, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            last_din = '0;
        end else if (out_wr_en) begin
            n_writes++;
            last_wr_cyc = cyc;
            if (exp_val.size() == 0) check("extra_write", 1, 0);
            else begin
                e = exp_val.pop_front();
                check("wr_data", out_din, e);
                last_din = e;
            end
        end else begin
            check("din_hold", out_din, last_din);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", busy, 1);
        end
        sa = 1'b0;
        sb = (cyc >= bst_from) && (cyc < bst_from + bst_len);
        af = (cyc >= af_from) && (cyc < af_from + af_len);
        if (rnd_pct > 0) begin
            sa = sa | ($urandom_range(99) < rnd_pct);
            sb = sb | ($urandom_range(99) < rnd_pct);
            af = af | ($urandom_range(99) < rnd_pct);
        end
        a_empty   = (qa.size() == 0) || sa;
        b_empty   = (qb.size() == 0) || sb;
        a_head    = (qa.size() != 0) ? qa[0] : 32'hDEAD_BEEF;
        b_head    = (qb.size() != 0) ? qb[0] : 32'hBEEF_DEAD;
        out_afull = af;
        #1;
        pend_a = a_rd_en;
        pend_b = b_rd_en;
        if (a_rd_en || b_rd_en)
            check("rd_legal", {a_rd_en & a_empty, b_rd_en & b_empty, a_rd_en & b_rd_en, out_afull, !busy}, 0);
    endtask

    task automatic load(input int xa, input int xb);
        qa.delete(); qb.delete();
        foreach (ra[i]) qa.push_back(ra[i]);
        foreach (rb[i]) qb.push_back(rb[i]);
        repeat (xa) qa.push_back($urandom);
        repeat (xb) qb.push_back($urandom);
    endtask

    task automatic rand_runs(input int n);
        logic [DW-1:0] v;
        ra.delete(); rb.delete();
        v = $urandom_range(3);
        repeat (n) begin ra.push_back(v); v = v + $urandom_range(3); end
        v = $urandom_range(3);
        repeat (n) begin rb.push_back(v); v = v + $urandom_range(3); end
    endtask

    task automatic run_merge(input int n, input int xa, input int xb, input int to, output int dcyc);
        build_expect();
        n_writes = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; cyc = 0;
        run_len = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (done_cnt == 0 && cyc < to) begin
            if (cyc == spur_at) begin start = 1'b1; run_len = CW'(1); end
            else start = 1'b0;
            tick();
        end
        start = 1'b0;
        check("done_seen", done_cnt != 0, 1);
        tick();
        check("busy_after", busy, 0);
        check("done_once", done_cnt, 1);
        check("n_writes", n_writes, 2 * n);
        check("exp_left", exp_val.size(), 0);
        check("unread_a", qa.size(), xa);
        check("unread_b", qb.size(), xb);
        if (n > 0) check("done_after_last", done_cyc, last_wr_cyc + 1);
        dcyc = done_cyc;
    endtask

    initial begin
        int d, n, xa, xb;
        reset = 1'b1; start = 1'b0; run_len = '0;
        a_empty = 1'b1; b_empty = 1'b1; out_afull = 1'b0;
        a_head = '0; b_head = '0;
        pend_a = 1'b0; pend_b = 1'b0; last_din = '0; cyc = 0; n_pops = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        ra = '{1, 4, 6, 9}; rb = '{2, 3, 7, 8};
        load(0, 0); run_merge(4, 0, 0, 40, d);
        check("basic_done_cyc", d, 10);

        ra = '{5, 5}; rb = '{5, 5};
        load(1, 1); run_merge(2, 1, 1, 40, d);
        check("ties_done_cyc", d, 6);

        ra = '{1, 2, 3}; rb = '{10, 11, 12};
        load(0, 2); run_merge(3, 0, 2, 40, d);
        check("early_done_cyc", d, 8);

        ra = '{1, 4, 6, 9}; rb = '{2, 3, 7, 8};
        bst_from = 3; bst_len = 3; af_from = 6; af_len = 2;
        load(0, 0); run_merge(4, 0, 0, 60, d);
        check("stall_done_cyc", d, 15);
        bst_len = 0; af_len = 0;

        ra.delete(); rb.delete();
        load(2, 2); run_merge(0, 2, 2, 10, d);
        check("zero_len_done_early", (d >= 1) && (d <= 2), 1);

        ra = '{1, 4, 6, 9}; rb = '{2, 3, 7, 8};
        spur_at = 4;
        load(0, 0); run_merge(4, 0, 0, 40, d);
        check("spur_done_cyc", d, 10);
        spur_at = -1;

        // Reset after three pops, then a fresh run of two.
        rand_runs(6); load(0, 0); build_expect();
        cyc = 0; n_pops = 0; run_len = CW'(6);
        start = 1'b1; tick(); start = 1'b0;
        while (n_pops < 3 && cyc < 40) tick();
        check("pops_before_rst", n_pops, 3);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_rd_en", {a_rd_en, b_rd_en}, 0);
        tick();
        check("rst_busy_held", busy, 0);
        ra = '{7, 20}; rb = '{3, 20};
        load(0, 0); run_merge(2, 0, 0, 40, d);
        check("after_rst_done_cyc", d, 6);

        rnd_pct = 25;
        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(1, 16); xa = $urandom_range(0, 2); xb = $urandom_range(0, 2);
            rand_runs(n); load(xa, xb);
            run_merge(n, xa, xb, 10 * n + 40, d);
        end
        rnd_pct = 0;

        rand_runs(256); load(1, 0); run_merge(256, 1, 0, 700, d);
        check("full_done_cyc", d, 514);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
